// File: rtl/mole_hit_detector.sv
// Whack-a-mole hit detector: latches mole waves, scores synchronised whacks, ends after NUM_WAVES.
// Optional: define MISS_PENALTY_EN to subtract misses from the score (floored at 0).
module mole_hit_detector #(
  parameter int NUM_HOLES   = 18,
  parameter int SCORE_W     = 10,
  parameter int NUM_WAVES   = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mole_clk,
  input  logic [NUM_HOLES-1:0] mole_positions,
  input  logic [NUM_HOLES-1:0] whack,
  output logic [NUM_HOLES-1:0] active_moles,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit,
  output logic                 miss,
  output logic                 done
);

  localparam int WAVE_W = $clog2(NUM_WAVES + 1);
  localparam int CNT_W  = $clog2(NUM_HOLES + 1);
  localparam int SUM_W  = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
  localparam int SUP_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [WAVE_W-1:0]  LAST_WAVE = WAVE_W'(NUM_WAVES);
  localparam logic [SUP_W-1:0]   SUP_DONE  = SUP_W'(SYNC_STAGES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_HOLES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  state_t                              state_r, state_nx_s;
  logic [SYNC_STAGES-1:0][NUM_HOLES-1:0] sync_r;
  logic [NUM_HOLES-1:0]                sync_prev_r, evt_r;
  logic [SUP_W-1:0]                    sup_cnt_r;
  logic                                mole_clk_r;
  logic [WAVE_W-1:0]                   wave_cnt_r, wave_cnt_nx_s;
  logic [NUM_HOLES-1:0]                active_nx_s, hits_s, misses_s;
  logic [SCORE_W-1:0]                  score_nx_s;
  logic                                hit_nx_s, miss_nx_s, done_nx_s, wave_edge_s;
  logic [SUM_W-1:0]                    sum_s, net_s;

  assign wave_edge_s = mole_clk & ~mole_clk_r;
  assign hits_s      = evt_r & active_moles;
  assign misses_s    = evt_r & ~active_moles;

  // Whack synchroniser, event detection with post-reset blanking, wave strobe history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r      <= '0;
      sync_prev_r <= '0;
      evt_r       <= '0;
      sup_cnt_r   <= '0;
      mole_clk_r  <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], whack};
      sync_prev_r <= sync_r[SYNC_STAGES-1];
      mole_clk_r  <= mole_clk;
      if (sup_cnt_r != SUP_DONE) begin
        sup_cnt_r <= sup_cnt_r + SUP_W'(1);
        evt_r     <= '0;
      end else begin
        evt_r     <= sync_r[SYNC_STAGES-1] ^ sync_prev_r;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (wave_edge_s) state_nx_s = PLAY;
        else             state_nx_s = IDLE;
      end
      PLAY: begin
        if (wave_edge_s && (wave_cnt_r == LAST_WAVE)) state_nx_s = DONE;
        else                                          state_nx_s = PLAY;
      end
      DONE:    state_nx_s = DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Saturating score update; the sum is widened so overflow is visible before truncation
  always_comb begin
    sum_s = SUM_W'(score) + SUM_W'(popcount(hits_s));
`ifdef MISS_PENALTY_EN
    if (sum_s < SUM_W'(popcount(misses_s))) net_s = {SUM_W{1'b0}};
    else                                    net_s = sum_s - SUM_W'(popcount(misses_s));
`else
    net_s = sum_s;
`endif
    if (net_s > SUM_W'(SCORE_MAX)) score_nx_s = SCORE_MAX;
    else                           score_nx_s = net_s[SCORE_W-1:0];
  end

  // Output / datapath next values
  always_comb begin
    active_nx_s   = active_moles;
    wave_cnt_nx_s = wave_cnt_r;
    hit_nx_s      = 1'b0;
    miss_nx_s     = 1'b0;
    done_nx_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (wave_edge_s) begin
          active_nx_s   = mole_positions;
          wave_cnt_nx_s = WAVE_W'(1);
        end else begin
          active_nx_s   = active_moles;
        end
      end
      PLAY: begin
        hit_nx_s  = |hits_s;
        miss_nx_s = |misses_s;
        // Whacks score against the old pattern; a coincident wave then overwrites it untouched
        if (wave_edge_s && (wave_cnt_r == LAST_WAVE)) begin
          active_nx_s = {NUM_HOLES{1'b0}};
          done_nx_s   = 1'b1;
        end else if (wave_edge_s) begin
          active_nx_s   = mole_positions;
          wave_cnt_nx_s = wave_cnt_r + WAVE_W'(1);
        end else begin
          active_nx_s = active_moles & ~hits_s;
        end
      end
      DONE: begin
        active_nx_s = {NUM_HOLES{1'b0}};
        done_nx_s   = 1'b1;
      end
      default: begin
        active_nx_s = {NUM_HOLES{1'b0}};
      end
    endcase
  end

  // Registered outputs and wave counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_moles <= '0;
      score        <= '0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      done         <= 1'b0;
      wave_cnt_r   <= '0;
    end else begin
      active_moles <= active_nx_s;
      hit          <= hit_nx_s;
      miss         <= miss_nx_s;
      done         <= done_nx_s;
      wave_cnt_r   <= wave_cnt_nx_s;
      if (state_r == PLAY) score <= score_nx_s;
      else                 score <= score;
    end
  end

endmodule

// File: tb/tb_mole_hit_detector.sv
// Self-checking bench for mole_hit_detector: directed scenarios plus randomized games
// compared against a cycle-level game model kept in the bench.
module tb_mole_hit_detector;
  localparam int NH = 18;
  localparam int SW = 4;
  localparam int NW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst, mole_clk;
  logic [NH-1:0] mole_positions, whack;
  logic [NH-1:0] active_moles;
  logic [SW-1:0] score;
  logic          hit, miss, done;

  int total = 0;
  int bad   = 0;

  // game model: phase 0 = waiting for first wave, 1 = playing, 2 = over
  int            m_phase, m_score, m_wave, ecnt;
  logic [NH-1:0] m_act;
  logic          m_hit, m_miss, mclk_prev;
  logic [NH-1:0] whist[$];

  always #5 clk = ~clk;

  mole_hit_detector #(.NUM_HOLES(NH), .SCORE_W(SW), .NUM_WAVES(NW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .mole_clk(mole_clk), .mole_positions(mole_positions),
    .whack(whack), .active_moles(active_moles), .score(score), .hit(hit),
    .miss(miss), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".active"}, 32'(active_moles), 32'(m_act));
    check({ph, ".score"},  32'(score),        32'(m_score));
    check({ph, ".hit"},    32'(hit),          32'(m_hit));
    check({ph, ".miss"},   32'(miss),         32'(m_miss));
    check({ph, ".done"},   32'(done),         32'(m_phase == 2));
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_wave = 0; ecnt = 0;
    m_act = '0; m_hit = 1'b0; m_miss = 1'b0; mclk_prev = 1'b0;
    whist = {};
    for (int i = 0; i < SS + 2; i++) whist.push_front('0);
  endtask

  // Game rules applied at one clock edge; whack levels reach scoring SS+1 edges later
  task automatic model_edge();
    logic [NH-1:0] evt, hits, misses;
    int net;
    bit wave;
    ecnt++;
    whist.push_front(whack);
    if (whist.size() > SS + 3) whist.delete(whist.size() - 1);
    evt  = (ecnt >= SS + 3) ? (whist[SS+1] ^ whist[SS+2]) : '0;
    wave = mole_clk && !mclk_prev;
    mclk_prev = mole_clk;
    m_hit = 1'b0; m_miss = 1'b0;
    if (m_phase == 1) begin
      hits   = evt & m_act;
      misses = evt & ~m_act;
      net = m_score + $countones(hits);
`ifdef MISS_PENALTY_EN
      net = net - $countones(misses);
`endif
      if (net < 0) net = 0;
      if (net > 2**SW - 1) net = 2**SW - 1;
      m_score = net;
      m_hit   = |hits;
      m_miss  = |misses;
      m_act   = m_act & ~hits;
    end
    if (m_phase != 2 && wave) begin
      if (m_phase == 1 && m_wave == NW) begin
        m_phase = 2;
        m_act   = '0;
      end else begin
        m_act   = mole_positions;
        m_wave++;
        m_phase = 1;
      end
    end
  endtask

  task automatic step(input logic [NH-1:0] w, input logic mc, input logic [NH-1:0] mp);
    whack = w; mole_clk = mc; mole_positions = mp;
    @(posedge clk);
    model_edge();
    #1;
    check_all("step");
  endtask

  // Reset is raised between edges and checked before any clock edge arrives
  task automatic do_reset(input logic [NH-1:0] w);
    #2;
    rst = 1'b1; whack = w; mole_clk = 1'b0; mole_positions = '0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [NH-1:0] w, hold;
    logic          mc;
    rst = 1'b1; whack = '0; mole_clk = 1'b0; mole_positions = '0;
    model_reset();
    do_reset('0);

    // idle cycles, then first wave with pattern 5
    for (int i = 0; i < 6; i++) step('0, 1'b0, '0);
    step('0, 1'b1, 18'h00005);
    check("load", 32'(active_moles), 32'h00005);
    step('0, 1'b0, 18'h00005);

    // single hit on hole 0, then a miss on the same hole
    w = 18'h00001;
    for (int i = 0; i < 5; i++) step(w, 1'b0, '0);
    check("hit0.score",  32'(score),        32'd1);
    check("hit0.active", 32'(active_moles), 32'h00004);
    w = 18'h00000;
    for (int i = 0; i < 5; i++) step(w, 1'b0, '0);

    // reload 5, then two hits in the same cycle
    step(w, 1'b1, 18'h00005);
    step(w, 1'b0, '0);
    w = 18'h00005;
    for (int i = 0; i < 5; i++) step(w, 1'b0, '0);
    check("dual.active", 32'(active_moles), 32'h0);

    // whack event coinciding with a wave edge carrying 3FFFF
    step(w, 1'b1, 18'h00005);
    step(w, 1'b0, '0);
    w = 18'h00004;
    step(w, 1'b0, '0);
    step(w, 1'b0, '0);
    step(w, 1'b0, '0);
    step(w, 1'b1, 18'h3FFFF);
    check("coinc.active", 32'(active_moles), 32'h3FFFF);

    // terminating wave edge, then whacks after game end
    step(w, 1'b0, '0);
    step(w, 1'b1, 18'h00FFF);
    check("end.done",   32'(done),         32'd1);
    check("end.active", 32'(active_moles), 32'h0);
    for (int i = 0; i < 8; i++) begin
      w = w ^ 18'h0000F;
      step(w, 1'b0, '0);
    end

    // reset mid-game with switches held up; those must not score after release
    hold = 18'h2AAAA;
    do_reset(hold);
    for (int i = 0; i < 6; i++) step(hold, 1'b0, '0);
    step(hold, 1'b1, 18'h3FFFF);
    check("held.score", 32'(score), 32'd0);
    step(hold, 1'b0, '0);

    // 18 simultaneous hits saturate the score
    w = hold ^ 18'h3FFFF;
    for (int i = 0; i < 5; i++) step(w, 1'b0, '0);
    check("sat.score", 32'(score), 32'(2**SW - 1));

    // randomized games
    for (int g = 0; g < 6; g++) begin
      w = NH'($urandom);
      do_reset(w);
      for (int i = 0; i < 150; i++) begin
        mc = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) w = w ^ (NH'($urandom) & NH'($urandom) & NH'($urandom));
        step(w, mc, NH'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
